// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register bank with a read-only hw_status word at index NUM_REGS-1.
// Defining AXI_REG_SLAVE_PROT_CHECK_EN rejects non-secure (prot[1]) in-range accesses with SLVERR.
module axi_lite_reg_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                                 s00_axi_aclk,
  input  logic                                 s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
  input  logic [2:0]                           s00_axi_awprot,
  input  logic                                 s00_axi_awvalid,
  output logic                                 s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
  input  logic                                 s00_axi_wvalid,
  output logic                                 s00_axi_wready,
  output logic [1:0]                           s00_axi_bresp,
  output logic                                 s00_axi_bvalid,
  input  logic                                 s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
  input  logic [2:0]                           s00_axi_arprot,
  input  logic                                 s00_axi_arvalid,
  output logic                                 s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
  output logic [1:0]                           s00_axi_rresp,
  output logic                                 s00_axi_rvalid,
  input  logic                                 s00_axi_rready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        hw_status,
  output logic [C_S_AXI_DATA_WIDTH*(NUM_REGS-1)-1:0] regs_out,
  output logic                                 wr_pulse
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] LIMIT = C_S_AXI_ADDR_WIDTH'(NUM_REGS * 4);
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [31:0] regs [NUM_REGS-1];
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [2:0] awprot_q, arprot_q;
  logic [31:0] wdata_q, rd_word;
  logic [3:0] wstrb_q;
  logic aw_held, w_held, ar_held, wr_ns, rd_ns, unused_prot;
  logic [1:0] wr_resp, rd_resp;
`ifdef AXI_REG_SLAVE_PROT_CHECK_EN
  assign wr_ns = awprot_q[1];
  assign rd_ns = arprot_q[1];
  assign unused_prot = ^{awprot_q[2], awprot_q[0], arprot_q[2], arprot_q[0]};
`else
  assign wr_ns = 1'b0;
  assign rd_ns = 1'b0;
  assign unused_prot = ^{awprot_q, arprot_q};
`endif
  // DECERR outranks every other error
  assign wr_resp = awaddr_q >= LIMIT ? 2'b11 : (wr_ns || awaddr_q[IW+1:2] == IW'(NUM_REGS-1)) ? 2'b10 : 2'b00;
  assign rd_resp = araddr_q >= LIMIT ? 2'b11 : rd_ns ? 2'b10 : 2'b00;
  always_comb begin
    rd_word = hw_status;
    for (int i = 0; i < NUM_REGS-1; i++) if (araddr_q[IW+1:2] == IW'(i)) rd_word = regs[i];
  end
  for (genvar i = 0; i < NUM_REGS-1; i++) begin : g_out
    assign regs_out[32*i +: 32] = regs[i];
  end
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset)
    if (s00_axi_areset) begin
      w_state <= W_IDLE;
      s00_axi_awready <= 1'b0;
      s00_axi_wready <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp <= 2'b00;
      wr_pulse <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      for (int i = 0; i < NUM_REGS-1; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (s00_axi_awready && s00_axi_awvalid) begin
            awaddr_q <= s00_axi_awaddr;
            awprot_q <= s00_axi_awprot;
            aw_held <= 1'b1;
            s00_axi_awready <= 1'b0;
          end else if (!aw_held) s00_axi_awready <= 1'b1;
          if (s00_axi_wready && s00_axi_wvalid) begin
            wdata_q <= s00_axi_wdata;
            wstrb_q <= s00_axi_wstrb;
            w_held <= 1'b1;
            s00_axi_wready <= 1'b0;
          end else if (!w_held) s00_axi_wready <= 1'b1;
          if (aw_held && w_held) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          if (wr_resp == 2'b00) begin
            for (int i = 0; i < NUM_REGS-1; i++)
              if (awaddr_q[IW+1:2] == IW'(i))
                for (int b = 0; b < 4; b++) if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
            wr_pulse <= 1'b1;
          end
          s00_axi_bvalid <= 1'b1;
          s00_axi_bresp <= wr_resp;
          aw_held <= 1'b0;
          w_held <= 1'b0;
          w_state <= W_RESP;
        end
        default: if (s00_axi_bready) begin
          s00_axi_bvalid <= 1'b0;
          s00_axi_awready <= 1'b1;
          s00_axi_wready <= 1'b1;
          w_state <= W_IDLE;
        end
      endcase
    end
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset)
    if (s00_axi_areset) begin
      r_state <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rresp <= 2'b00;
      s00_axi_rdata <= '0;
      ar_held <= 1'b0;
      araddr_q <= '0;
      arprot_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_held) begin
            s00_axi_rdata <= rd_resp == 2'b00 ? rd_word : '0;
            s00_axi_rresp <= rd_resp;
            s00_axi_rvalid <= 1'b1;
            ar_held <= 1'b0;
            r_state <= R_DATA;
          end else if (s00_axi_arready && s00_axi_arvalid) begin
            araddr_q <= s00_axi_araddr;
            arprot_q <= s00_axi_arprot;
            ar_held <= 1'b1;
            s00_axi_arready <= 1'b0;
          end else s00_axi_arready <= 1'b1;
        end
        default: if (s00_axi_rready) begin
          s00_axi_rvalid <= 1'b0;
          s00_axi_arready <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI4-Lite responder (slave) exposing a bank of 32-bit read/write control registers plus one read-only hardware status word.
- Target of the GPIF memory-access master path: sits behind the interconnect and turns single-beat AXI4-Lite reads and writes into register updates and status readback.
- Handles one outstanding read and one outstanding write at a time. Returns OKAY, SLVERR or DECERR responses.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, byte-address width.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- NUM_REGS, 16, number of register words (power of 2, ≥2). Index NUM_REGS-1 is the read-only status word.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_areset  in  1  asynchronous, active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  write protection.
- s00_axi_awvalid  in  1 / s00_axi_awready  out  1  write address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte strobes.
- s00_axi_wvalid  in  1 / s00_axi_wready  out  1  write data handshake.
- s00_axi_bresp  out  2 / s00_axi_bvalid  out  1 / s00_axi_bready  in  1  write response channel.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  read protection.
- s00_axi_arvalid  in  1 / s00_axi_arready  out  1  read address handshake.
- s00_axi_rdata  out  32 / s00_axi_rresp  out  2 / s00_axi_rvalid  out  1 / s00_axi_rready  in  1  read data channel.
- hw_status  in  32  value returned when reading index NUM_REGS-1.
- regs_out  out  32*(NUM_REGS-1)  flattened register contents; word i is at bits [32i+31:32i].
- wr_pulse  out  1  one-cycle strobe when a register write commits.

Behaviour:
- Reset (async assert, sync release): all regs = 0. awready, wready, arready, bvalid, rvalid, wr_pulse = 0. bresp, rresp = 2'b00. rdata = 0.
- Ready signals are registered. awready, wready and arready rise in the first clock after reset release.
- Decode:
  - index = addr[clog2(NUM_REGS)+1:2]; addr[1:0] ignored.
  - addr ≥ NUM_REGS*4 → DECERR (2'b11).
  - Write to index NUM_REGS-1 → SLVERR (2'b10), no update.
- Write FSM states: W_IDLE, W_COMMIT, W_RESP.
  - W_IDLE: AW and W accepted independently. awready drops the cycle after the AW handshake; wready drops the cycle after the W handshake. Address and data are latched.
  - Once both are held → W_COMMIT.
  - W_COMMIT (1 cycle): byte-wise update per wstrb if OKAY; wr_pulse = 1 only on an OKAY commit; set bvalid and bresp → W_RESP.
  - W_RESP: hold bvalid and bresp stable until bready. On the bvalid&&bready cycle, clear bvalid and re-raise awready and wready → W_IDLE.
  - Minimum latency: AW+W in same cycle → bvalid 2 cycles later.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = 1. On the handshake, drop arready and on the next edge register rdata and rresp, set rvalid → R_DATA.
  - DECERR and SLVERR reads return rdata = 0.
  - R_DATA: hold rdata, rresp and rvalid until rready. Then clear rvalid and set arready → R_IDLE.
  - Read latency = 1 cycle after the AR handshake.
- Simultaneous events:
  - Read sampling a register in the same cycle as a W_COMMIT to it returns the pre-write value.
  - Read and write channels are fully independent.
- wstrb = 0 with a valid address: OKAY response, no data change, wr_pulse still asserted.
- Reset mid-transaction: all valids drop immediately; the pending transaction is discarded; registers are cleared.

Optional Feature:
- Macro: AXI_REG_SLAVE_PROT_CHECK_EN.
- Defined:
  - Any access with prot[1] = 1 (non-secure) to an in-range address gets SLVERR.
  - The write is dropped with no wr_pulse; the read returns 0.
  - DECERR still takes priority for out-of-range addresses.
- Undefined: awprot and arprot are ignored.

Test Plan:
- Reset, write 0xDEADBEEF to addr 0x04 with AW and W in the same cycle, strb 4'hF → bvalid 2 cycles later, bresp 00, wr_pulse once; read 0x04 → rdata 0xDEADBEEF, rresp 00, latency 1.
- W presented 3 cycles before AW to addr 0x08, data 0x12345678, strb 4'b0101 → register = 0x00340078; bresp 00 only after AW accepted.
- hw_status = 0xA5A55A5A: read addr 0x3C → 0xA5A55A5A, OKAY. Write 0x3C → SLVERR, readback still hw_status, no wr_pulse.
- Read addr 0x40 and write addr 0x100 → rresp 11, rdata 0, bresp 11, no register changes.
- bready and rready held low 5 cycles → bvalid, rvalid and response payloads stable; awready and arready stay 0 until the response handshake.
- With AXI_REG_SLAVE_PROT_CHECK_EN: write 0x1 to addr 0x00 with awprot = 3'b010 → SLVERR, reg0 unchanged. Same write with awprot = 3'b000 → OKAY, reg0 = 1.
